// File: rtl/if_fetch_unit.sv
// Instruction fetch: one word per memory completion into IF/ID; zero added latency, one-entry skid on ID stall.
// Branch redirects drain any in-flight request. FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        proc2Imem_req,
   output logic [31:0] proc2Imem_addr,
   input  logic [31:0] Imem2proc_data,
   input  logic        Imem2proc_valid,
   input  logic        id_stall,
   input  logic        ex_take_branch,
   input  logic [31:0] ex_target_pc,
   output logic [31:0] if_id_IR,
   output logic [31:0] if_id_PC,
   output logic [31:0] if_id_NPC,
   output logic        if_id_valid_inst
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] if_stall_cycles,
   output logic [31:0] if_redirect_cnt
`endif
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] drain_pc_q, drain_pc_d;
   logic [31:0] skid_ir_q, skid_ir_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] npc_q, npc_d;
   logic        vld_q, vld_d;
   logic        mem_done;

   // A filled skid buffer (HOLD) is the only reason not to request.
   assign proc2Imem_req  = rst && (state_q != HOLD);
   assign proc2Imem_addr = (state_q == DRAIN) ? drain_pc_q : fetch_pc_q;
   assign mem_done       = proc2Imem_req && Imem2proc_valid;

   assign if_id_IR         = ir_q;
   assign if_id_PC         = pc_q;
   assign if_id_NPC        = npc_q;
   assign if_id_valid_inst = vld_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drain_pc_d = drain_pc_q;
      skid_ir_d  = skid_ir_q;
      skid_pc_d  = skid_pc_q;
      ir_d       = ir_q;
      pc_d       = pc_q;
      npc_d      = npc_q;
      vld_d      = vld_q;

      if (ex_take_branch) begin
         ir_d       = NOP_INST;
         vld_d      = 1'b0;
         fetch_pc_d = ex_target_pc & ~32'h3;
         case (state_q)
            FETCH: begin
               if (!mem_done) begin
                  state_d    = DRAIN;
                  drain_pc_d = fetch_pc_q;
               end
            end
            HOLD:    state_d = FETCH;
            // A completion in the same cycle finishes the drain immediately.
            DRAIN:   if (mem_done) state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (mem_done) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (id_stall) begin
                     skid_ir_d = Imem2proc_data;
                     skid_pc_d = fetch_pc_q;
                     state_d   = HOLD;
                  end else begin
                     ir_d  = Imem2proc_data;
                     pc_d  = fetch_pc_q;
                     npc_d = fetch_pc_q + 32'd4;
                     vld_d = 1'b1;
                  end
               end else if (!id_stall) begin
                  ir_d  = NOP_INST;
                  vld_d = 1'b0;
               end
            end
            HOLD: begin
               if (!id_stall) begin
                  ir_d    = skid_ir_q;
                  pc_d    = skid_pc_q;
                  npc_d   = skid_pc_q + 32'd4;
                  vld_d   = 1'b1;
                  state_d = FETCH;
               end
            end
            DRAIN: begin
               if (mem_done) state_d = FETCH;
               if (!id_stall) begin
                  ir_d  = NOP_INST;
                  vld_d = 1'b0;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         drain_pc_q <= '0;
         skid_ir_q  <= '0;
         skid_pc_q  <= '0;
         ir_q       <= NOP_INST;
         pc_q       <= '0;
         npc_q      <= '0;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drain_pc_q <= drain_pc_d;
         skid_ir_q  <= skid_ir_d;
         skid_pc_q  <= skid_pc_d;
         ir_q       <= ir_d;
         pc_q       <= pc_d;
         npc_q      <= npc_d;
         vld_q      <= vld_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if ((id_stall || state_q == DRAIN) && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (ex_take_branch && redir_cnt_q != 32'hFFFF_FFFF)
         redir_cnt_d = redir_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign if_stall_cycles = stall_cnt_q;
   assign if_redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory, transaction-level IF/ID model, directed cases then random traffic.
`timescale 1ns/1ps
module tb_if_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        proc2Imem_req;
   logic [31:0] proc2Imem_addr;
   logic [31:0] Imem2proc_data = '0;
   logic        Imem2proc_valid = 1'b0;
   logic        id_stall = 1'b0;
   logic        ex_take_branch = 1'b0;
   logic [31:0] ex_target_pc = '0;
   logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
   logic        if_id_valid_inst;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] if_stall_cycles, if_redirect_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .proc2Imem_req    (proc2Imem_req),
      .proc2Imem_addr   (proc2Imem_addr),
      .Imem2proc_data   (Imem2proc_data),
      .Imem2proc_valid  (Imem2proc_valid),
      .id_stall         (id_stall),
      .ex_take_branch   (ex_take_branch),
      .ex_target_pc     (ex_target_pc),
      .if_id_IR         (if_id_IR),
      .if_id_PC         (if_id_PC),
      .if_id_NPC        (if_id_NPC),
      .if_id_valid_inst (if_id_valid_inst)
`ifdef FETCH_PERF_CNT_EN
      ,
      .if_stall_cycles  (if_stall_cycles),
      .if_redirect_cnt  (if_redirect_cnt)
`endif
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Reference model: IF/ID contents, next PC to deliver, next PC to request,
   // words accepted but not yet delivered, and whether an abandoned request is in flight.
   logic        m_vld;
   logic [31:0] m_ir, m_pc, m_npc, m_exp_pc, m_req_pc;
   int          m_count;
   bit          m_drain;
   logic [31:0] m_stall, m_redir;

   bit          mem_pend;
   int          mem_cnt, mem_lat, lat_cfg;
   logic [31:0] mem_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      id_stall = 1'b0;
      ex_take_branch = 1'b0;
      Imem2proc_valid = 1'b0;
      #1;
      chk("rst_vld", {31'b0, if_id_valid_inst}, 32'd0);
      chk("rst_ir", if_id_IR, NOP);
      chk("rst_pc", if_id_PC, 32'd0);
      chk("rst_npc", if_id_NPC, 32'd0);
      chk("rst_req", {31'b0, proc2Imem_req}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_stall_cnt", if_stall_cycles, 32'd0);
      chk("rst_redir_cnt", if_redirect_cnt, 32'd0);
`endif
      repeat (2) @(negedge clk);
      chk("rst_req_hold", {31'b0, proc2Imem_req}, 32'd0);
      m_vld = 1'b0; m_ir = NOP; m_pc = '0; m_npc = '0;
      m_exp_pc = RPC; m_req_pc = RPC; m_count = 0; m_drain = 1'b0;
      m_stall = '0; m_redir = '0;
      mem_pend = 1'b0; mem_cnt = 0;
      rst = 1'b1;
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic run_cycle(input bit stall, input bit br, input logic [31:0] tgt);
      logic        req, comp;
      logic [31:0] addr;
      bit          acc;
      int          avail;
      id_stall = stall;
      ex_take_branch = br;
      ex_target_pc = tgt;
      #1;
      req  = proc2Imem_req;
      addr = proc2Imem_addr;
      chk("req", {31'b0, req}, {31'b0, (m_count == 0)});
      if (req) begin
         if (!mem_pend) begin
            mem_pend = 1'b1;
            mem_cnt  = 0;
            mem_addr = addr;
            mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            if (!m_drain) chk("req_addr", addr, m_req_pc);
         end else begin
            chk("addr_stable", addr, mem_addr);
         end
         Imem2proc_valid = (mem_cnt == mem_lat);
         Imem2proc_data  = mem_word(addr);
      end else begin
         Imem2proc_valid = 1'($urandom_range(0, 1));
         Imem2proc_data  = $urandom;
      end
      comp = req && Imem2proc_valid;
      #1;
      if ((stall || m_drain) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (br && m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 32'd1;
      acc = comp && !br && !m_drain;
      if (comp) mem_pend = 1'b0;
      else if (req) mem_cnt++;
      if (br) begin
         m_drain  = req && !comp;
         m_req_pc = tgt & ~32'h3;
         m_exp_pc = tgt & ~32'h3;
         m_vld    = 1'b0;
         m_ir     = NOP;
         m_count  = 0;
      end else begin
         if (comp) m_drain = 1'b0;
         if (acc) m_req_pc = m_req_pc + 32'd4;
         avail = m_count + int'(acc);
         if (!stall) begin
            if (avail > 0) begin
               m_vld = 1'b1;
               m_pc  = m_exp_pc;
               m_npc = m_exp_pc + 32'd4;
               m_ir  = mem_word(m_exp_pc);
               m_exp_pc = m_exp_pc + 32'd4;
               avail--;
            end else begin
               m_vld = 1'b0;
               m_ir  = NOP;
            end
         end
         m_count = avail;
      end
      @(posedge clk);
      @(negedge clk);
      chk("valid", {31'b0, if_id_valid_inst}, {31'b0, m_vld});
      chk("IR", if_id_IR, m_ir);
      if (m_vld) begin
         chk("PC", if_id_PC, m_pc);
         chk("NPC", if_id_NPC, m_npc);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", if_stall_cycles, m_stall);
      chk("redir_cnt", if_redirect_cnt, m_redir);
`endif
   endtask

   initial begin
      lat_cfg = 0;
      @(negedge clk);

      // Zero-latency first fetch.
      do_reset();
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("first_vld", {31'b0, if_id_valid_inst}, 32'd1);
      chk("first_pc", if_id_PC, 32'd0);
      chk("first_npc", if_id_NPC, 32'd4);
      chk("first_ir", if_id_IR, 32'h00A0_0093);
      chk("first_next_addr", proc2Imem_addr, 32'd4);

      // Valid on the third request cycle: two bubbles between words.
      do_reset();
      lat_cfg = 2;
      for (int i = 0; i < 9; i++) begin
         run_cycle(1'b0, 1'b0, 32'd0);
         chk("lat_vld", {31'b0, if_id_valid_inst}, {31'b0, ((i % 3) == 2)});
         if ((i % 3) == 2) chk("lat_pc", if_id_PC, 32'(4 * (i / 3)));
         else chk("lat_bubble_ir", if_id_IR, 32'h0000_0013);
      end

      // Stall while PC=8 completes, then release; then redirect during PC=16.
      do_reset();
      for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 1'b0, 32'd0);
         chk("stall_pc", if_id_PC, 32'd4);
         chk("stall_req", {31'b0, proc2Imem_req}, 32'd0);
      end
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("release_pc", if_id_PC, 32'd8);
      chk("release_vld", {31'b0, if_id_valid_inst}, 32'd1);
      chk("release_addr", proc2Imem_addr, 32'd12);
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("no_dup_vld", {31'b0, if_id_valid_inst}, 32'd0);
      run_cycle(1'b0, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("pc12", if_id_PC, 32'd12);
      run_cycle(1'b0, 1'b0, 32'd0);
      run_cycle(1'b0, 1'b1, 32'h0000_0103);
      chk("drain_vld", {31'b0, if_id_valid_inst}, 32'd0);
      chk("drain_addr", proc2Imem_addr, 32'd16);
      chk("drain_req", {31'b0, proc2Imem_req}, 32'd1);
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("drain_done_vld", {31'b0, if_id_valid_inst}, 32'd0);
      chk("target_addr", proc2Imem_addr, 32'h0000_0100);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 32'd0);
      chk("target_pc", if_id_PC, 32'h0000_0100);

      // Redirect together with stall while the skid buffer is full.
      do_reset();
      lat_cfg = 0;
      run_cycle(1'b1, 1'b0, 32'd0);
      chk("hold_req", {31'b0, proc2Imem_req}, 32'd0);
      run_cycle(1'b1, 1'b1, 32'h0000_0200);
      chk("hold_br_vld", {31'b0, if_id_valid_inst}, 32'd0);
      chk("hold_br_ir", if_id_IR, 32'h0000_0013);
      chk("hold_br_addr", proc2Imem_addr, 32'h0000_0200);
`ifdef FETCH_PERF_CNT_EN
      chk("hold_br_redir_cnt", if_redirect_cnt, 32'd1);
`endif
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("hold_br_pc", if_id_PC, 32'h0000_0200);

      // Reset in the middle of a transaction at PC=20.
      do_reset();
      for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 32'd0);
      lat_cfg = 3;
      run_cycle(1'b0, 1'b0, 32'd0);
      chk("mid_addr", proc2Imem_addr, 32'd20);
      do_reset();
      #1;
      chk("post_rst_req", {31'b0, proc2Imem_req}, 32'd1);
      chk("post_rst_addr", proc2Imem_addr, 32'd0);
      for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'd0);

      // Random traffic.
      lat_cfg = -1;
      for (int i = 0; i < 3000; i++) begin
         run_cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have a parameter NOP_INST, default 32'h0000_0013, meaning the encoding driven on if_id_IR when the slot is invalid.
REQ-003 Port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port proc2Imem_req  output  1  instruction-memory request.
REQ-006 Port proc2Imem_addr  output  32  fetch address, word-aligned.
REQ-007 Port Imem2proc_data  input  32  instruction word returned by memory.
REQ-008 Port Imem2proc_valid  input  1  completes the current request.
REQ-009 Port id_stall  input  1  ID cannot accept; the IF/ID register must hold.
REQ-010 Port ex_take_branch  input  1  redirect request from EX.
REQ-011 Port ex_target_pc  input  32  redirect target.
REQ-012 Port if_id_IR  output  32  instruction handed to ID.
REQ-013 Port if_id_PC  output  32  PC of if_id_IR.
REQ-014 Port if_id_NPC  output  32  if_id_PC+4.
REQ-015 Port if_id_valid_inst  output  1  if_id_IR is a real fetched instruction.

Function
REQ-016 The FSM SHALL use states FETCH, HOLD and DRAIN, and SHALL enter FETCH at reset.
REQ-017 Memory protocol: memory latches proc2Imem_addr on the first req cycle; the transaction completes in any cycle with req=1 and Imem2proc_valid=1; latency is zero or more cycles; address is held stable until completion.
REQ-018 In FETCH, req=1 and addr=fetch_pc; completion with id_stall=0 loads IR/PC/NPC, sets valid=1 and sets fetch_pc+=4 (32-bit wrap).
REQ-019 In FETCH, completion with id_stall=1 stores word+PC in a one-entry skid buffer, advances fetch_pc by 4, and enters HOLD; the IF/ID register holds.
REQ-020 In HOLD, req=0; the first cycle with id_stall=0 moves the skid buffer into IF/ID with valid=1 and returns to FETCH.
REQ-021 In any cycle with id_stall=0 and no new word delivered, IF/ID SHALL take valid=0 and IR=NOP_INST (bubble).
REQ-022 In any cycle with id_stall=1 and no redirect, all IF/ID outputs SHALL hold their values.
REQ-023 ex_take_branch has highest priority: IF/ID is cleared (valid=0, IR=NOP_INST), the skid buffer is discarded, and fetch_pc is set to {ex_target_pc[31:2],2'b00}, regardless of id_stall.
REQ-024 A redirect in FETCH with req asserted and no completion SHALL enter DRAIN; if completion occurs in the same cycle, the word SHALL be discarded and the state SHALL remain FETCH.
REQ-025 In DRAIN, req SHALL stay 1 with the old address; the completion word SHALL be discarded and the state SHALL return to FETCH at the new fetch_pc.
REQ-026 A redirect arriving while in DRAIN SHALL update the target only, and SHALL remain in DRAIN.
REQ-027 A word SHALL never be delivered twice or out of PC order.

Reset
REQ-028 Asserting rst low SHALL immediately force: state=FETCH, fetch_pc=RESET_PC, if_id_IR=NOP_INST, if_id_PC=0, if_id_NPC=0, if_id_valid_inst=0, skid buffer empty, counters 0.
REQ-029 While rst=0, proc2Imem_req SHALL be 0; after deassertion, the first req SHALL occur in the next cycle with addr=RESET_PC.
REQ-030 Reset asserted during a pending transaction SHALL abandon it.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: if defined, the block SHALL add outputs if_stall_cycles[31:0], counting cycles with id_stall=1 or state=DRAIN, and if_redirect_cnt[31:0], counting cycles with ex_take_branch=1; both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-032 If the macro is undefined, the block SHALL have neither those ports nor that logic, and SHALL otherwise behave identically.

Verification
REQ-033 Zero-latency memory returning 32'h00A00093 at address 0, no stall -> one cycle after reset release, IF/ID holds PC=0, NPC=4, valid=1; addr=4 next.
REQ-034 3-cycle memory latency -> two bubbles (valid=0, IR=32'h13) between delivered words; PCs 0,4,8 in order.
REQ-035 id_stall=1 for 4 cycles while the word at PC=8 completes -> IF/ID keeps PC=4; HOLD with req=0; after release PC=8 delivered once; next addr=12.
REQ-036 ex_take_branch=1, target 32'h0000_0103, during a pending 3-cycle fetch of PC=16 -> DRAIN; the PC=16 word is dropped; next req addr=32'h100; IF/ID valid=0 during the drain.
REQ-037 Redirect and stall asserted together in HOLD -> skid buffer dropped, IF/ID cleared, fetch at target; if_redirect_cnt=1 when FETCH_PERF_CNT_EN is defined.
REQ-038 rst asserted mid-transaction at PC=20 -> outputs at reset values immediately; the first req after release is at RESET_PC.
